fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage driven by the 4-phase multi-cycle sequencer (FETCH/DECODE/MEMORY/WRITEBACK).
//  In FETCH: issues one req/gnt/rvalid read to instruction memory, latches the word into the IR.
//  Holds the sequencer in FETCH via stall until the word returns; the sequencer advances only when stall==0.
//  Owns the PC; updates it once per instruction in WRITEBACK (sequential +4 or branch/jump target).
// PARAMETERS
//  XLEN            32         PC/address width
//  RESET_PC        'h0        PC value after reset
//  TIMEOUT_CYCLES  16         watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)
// PORTS
//  clk          in   1     clock; all state on posedge
//  reset_n      in   1     asynchronous, active-low reset
//  phase        in   2     sequencer state: 0=FETCH 1=DECODE 2=MEMORY 3=WRITEBACK
//  pc_load      in   1     in WRITEBACK: take pc_target instead of pc+4
//  pc_target    in   XLEN  branch/jump target
//  imem_req     out  1     read request; held until imem_gnt
//  imem_addr    out  XLEN  read address (= pc), stable while imem_req
//  imem_gnt     in   1     request accepted
//  imem_rvalid  in   1     read data valid
//  imem_rdata   in   32    read data
//  imem_err     in   1     bus error, qualified by imem_rvalid
//  instr        out  32    instruction register
//  instr_valid  out  1     instr holds a good word for the current instruction
//  pc           out  XLEN  address of the current instruction
//  stall        out  1     hold sequencer in FETCH
//  fetch_fault  out  1     last fetch errored (or timed out)
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0,
//   fetch_fault=0, FSM=IDLE; stall=0 is combinational, not a reset value. Outstanding transaction abandoned; any later response ignored.
//  FSM IDLE->REQ->WAIT->DONE->IDLE:
//   IDLE: phase==FETCH -> REQ; instr_valid<=0, fetch_fault<=0.
//   REQ : imem_req=1, imem_addr=pc. gnt&rvalid same cycle -> capture, DONE; gnt alone -> WAIT.
//   WAIT: imem_req=0; rvalid -> capture, DONE.
//   DONE: phase!=FETCH -> IDLE; else stay DONE (never refetch within one FETCH phase).
//  Capture: err=0 -> instr<=rdata, instr_valid<=1. err=1 -> instr<=NOP, instr_valid<=0, fetch_fault<=1.
//  stall = (phase==FETCH) && (FSM!=DONE), combinational. Min FETCH length 3 cycles (IDLE,REQ+gnt+rvalid,DONE).
//  rvalid in IDLE/REQ-without-gnt/DONE: ignored.
//  phase leaves FETCH while REQ/WAIT (sequencer violation): transaction still completes and captures; FSM goes IDLE after capture.
//  PC: on posedge with phase==WRITEBACK: pc <= pc_load ? {pc_target[XLEN-1:2],2'b00} : pc+4.
//   Arithmetic mod 2^XLEN (wraps 'hFFFF_FFFC -> 0). WRITEBACK held several cycles updates only on its first cycle.
//  instr/fetch_fault hold value through DECODE/MEMORY/WRITEBACK until the next FETCH start.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined: counter clears on entering REQ, counts each cycle in REQ/WAIT. When it reaches
//   TIMEOUT_CYCLES: drop imem_req, instr<=NOP, instr_valid<=0, fetch_fault<=1, FSM->DONE.
//   Any late rvalid is ignored until the next REQ.
//  Not defined: no counter logic; REQ/WAIT wait indefinitely; TIMEOUT_CYCLES unused.
// TESTING
//  Reset, zero-wait memory (gnt+rvalid same cycle as req), rdata=32'h00500093 -> imem_addr=0, instr=00500093,
//   instr_valid=1, stall high 2 cycles of FETCH, pc=4 after WRITEBACK.
//  gnt 3 cycles late, rvalid 2 cycles after gnt -> imem_req held with addr stable until gnt;
//   stall held until the DONE cycle; one capture only.
//  WRITEBACK with pc_load=1, pc_target='h103 -> next imem_addr='h100; pc='hFFFF_FFFC, pc_load=0 -> pc=0.
//  rvalid with imem_err=1 -> instr=32'h00000013, instr_valid=0, fetch_fault=1; cleared at next FETCH start.
//  reset_n low while in WAIT, then rvalid arrives -> all outputs at reset values immediately, response ignored.
//  FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no gnt -> at cycle 16 imem_req=0, fetch_fault=1, stall=0; without macro, stall stays high.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: req/gnt address phase, rvalid/rdata/err response phase.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: one imem read per FETCH phase into IR, stall until the word lands (min 3 cycles); PC advance in WRITEBACK.
// Optional FETCH_TIMEOUT_EN adds a watchdog that aborts REQ/WAIT after TIMEOUT_CYCLES and flags a fetch fault.
module fetch_unit #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      phase,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_target,
  fetch_unit_if.master    imem,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic            stall,
  output logic            fetch_fault
);

  localparam logic [1:0]  PH_FETCH = 2'd0;
  localparam logic [1:0]  PH_WB    = 2'd3;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      phase_q;
  logic            capture;
  logic            timeout;
  logic            busy;
  logic            unused_ok;

  assign busy      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign unused_ok = ^pc_target[1:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Watchdog compiled out: never fires.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (phase == PH_FETCH) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end
      end
      S_REQ: begin
        if (imem.imem_gnt && imem.imem_rvalid) begin
          capture = 1'b1;
        end else if (!timeout && imem.imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        capture = imem.imem_rvalid;
      end
      S_DONE: begin
        if (phase != PH_FETCH) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A response landing on the watchdog's last cycle still wins.
    if (capture) begin
      state_d = S_DONE;
      if (imem.imem_err) begin
        instr_d = NOP;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end else begin
        instr_d = imem.imem_rdata;
        valid_d = 1'b1;
      end
    end else if (timeout) begin
      state_d = S_DONE;
      instr_d = NOP;
      valid_d = 1'b0;
      fault_d = 1'b1;
    end
  end

  // PC moves only on the first cycle of a WRITEBACK phase, however long it is held.
  always_comb begin
    pc_d = pc_q;
    if ((phase == PH_WB) && (phase_q != PH_WB)) begin
      pc_d = pc_load ? {pc_target[XLEN-1:2], 2'b00} : pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      instr_q <= NOP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      pc_q    <= RESET_PC;
      phase_q <= PH_FETCH;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      pc_q    <= pc_d;
      phase_q <= phase;
    end
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign fetch_fault    = fault_q;
  assign pc             = pc_q;
  assign stall          = (phase == PH_FETCH) && (state_q != S_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a response scoreboard.
module tb_fetch_unit;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      phase;
  logic            pc_load;
  logic [XLEN-1:0] pc_target;
  logic [31:0]     instr;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic            stall;
  logic            fetch_fault;

  exp_t sb[$];
  exp_t last_exp;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN(XLEN),
    .RESET_PC('0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .phase(phase),
    .pc_load(pc_load),
    .pc_target(pc_target),
    .imem(bus.master),
    .instr(instr),
    .instr_valid(instr_valid),
    .pc(pc),
    .stall(stall),
    .fetch_fault(fetch_fault)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.imem_err    = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    exp_t e;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    bus.imem_err    = err;
    if (err) e = '{instr: NOP, valid: 1'b0, fault: 1'b1};
    else     e = '{instr: data, valid: 1'b1, fault: 1'b0};
    sb.push_back(e);
  endtask

  // Starts and ends at a falling edge.
  task automatic do_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data,
                          input logic err, input logic [31:0] addr);
    exp_t e;
    phase = 2'd0;
    #1;
    chk1("idle_stall", stall, 1'b1);
    chk1("idle_req", bus.imem_req, 1'b0);
    tick();
    chk1("start_valid_clr", instr_valid, 1'b0);
    chk1("start_fault_clr", fetch_fault, 1'b0);
    for (int i = 0; i < gnt_dly; i++) begin
      chk1("req_held", bus.imem_req, 1'b1);
      chk32("addr_stable", bus.imem_addr, addr);
      tick();
    end
    chk1("req_at_gnt", bus.imem_req, 1'b1);
    chk32("addr_at_gnt", bus.imem_addr, addr);
    chk1("stall_req", stall, 1'b1);
    bus.imem_gnt = 1'b1;
    if (rv_dly == 0) respond(data, err);
    tick();
    bus_idle();
    for (int i = 0; i < rv_dly; i++) begin
      chk1("wait_req_low", bus.imem_req, 1'b0);
      chk1("wait_stall", stall, 1'b1);
      if (i == rv_dly - 1) respond(data, err);
      tick();
      bus_idle();
    end
    chk1("done_stall", stall, 1'b0);
    chk1("done_req", bus.imem_req, 1'b0);
    if (sb.size() == 0) begin
      chk1("sb_nonempty", 1'b0, 1'b1);
      e = '{instr: NOP, valid: 1'b0, fault: 1'b0};
    end else begin
      e = sb.pop_front();
    end
    chk32("instr", instr, e.instr);
    chk1("instr_valid", instr_valid, e.valid);
    chk1("fetch_fault", fetch_fault, e.fault);
    // A stray response while parked in DONE must not refetch or recapture.
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0BAD_0BAD;
    tick();
    bus_idle();
    chk1("no_refetch", bus.imem_req, 1'b0);
    chk32("instr_kept", instr, e.instr);
    last_exp = e;
  endtask

  task automatic do_wb(input logic ld, input logic [31:0] tgt, input int hold,
                       input logic [31:0] exp_pc);
    phase = 2'd1;
    tick();
    chk32("hold_instr", instr, last_exp.instr);
    chk1("hold_fault", fetch_fault, last_exp.fault);
    phase = 2'd2;
    tick();
    chk1("hold_valid", instr_valid, last_exp.valid);
    phase     = 2'd3;
    pc_load   = ld;
    pc_target = tgt;
    repeat (hold) tick();
    chk32("pc_after_wb", pc, exp_pc);
    pc_load   = 1'b0;
    pc_target = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    phase     = 2'd1;
    pc_load   = 1'b0;
    pc_target = '0;
    bus_idle();
    last_exp  = '{instr: NOP, valid: 1'b0, fault: 1'b0};
    tick();
    tick();
    chk32("rst_pc", pc, 32'h0);
    chk32("rst_instr", instr, NOP);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_req", bus.imem_req, 1'b0);
    chk1("rst_fault", fetch_fault, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    reset_n = 1'b1;
    tick();

    do_fetch(0, 0, 32'h0050_0093, 1'b0, 32'h0);
    do_wb(1'b0, '0, 2, 32'h4);
    do_fetch(3, 2, 32'hDEAD_BEEF, 1'b0, 32'h4);
    do_wb(1'b1, 32'h103, 1, 32'h100);
    do_fetch(0, 1, 32'h1234_5678, 1'b0, 32'h100);
    do_wb(1'b0, '0, 1, 32'h104);
    do_fetch(1, 0, 32'hFFFF_FFFF, 1'b1, 32'h104);
    do_wb(1'b1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC);
    do_fetch(0, 0, 32'h0000_0093, 1'b0, 32'hFFFF_FFFC);
    do_wb(1'b0, '0, 3, 32'h0);
    do_wb(1'b1, 32'h40, 1, 32'h40);

    // Reset lands mid-transaction; the late response must be dropped.
    phase = 2'd0;
    tick();
    bus.imem_gnt = 1'b1;
    tick();
    bus_idle();
    chk1("wait_before_rst", bus.imem_req, 1'b0);
    reset_n = 1'b0;
    #1;
    chk32("arst_pc", pc, 32'h0);
    chk32("arst_instr", instr, NOP);
    chk1("arst_valid", instr_valid, 1'b0);
    chk1("arst_req", bus.imem_req, 1'b0);
    chk1("arst_fault", fetch_fault, 1'b0);
    tick();
    phase           = 2'd1;
    reset_n         = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0777;
    tick();
    bus_idle();
    chk32("late_rsp_instr", instr, NOP);
    chk1("late_rsp_valid", instr_valid, 1'b0);
    last_exp = '{instr: NOP, valid: 1'b0, fault: 1'b0};
    do_fetch(2, 0, 32'hCAFE_0013, 1'b0, 32'h0);
    do_wb(1'b0, '0, 1, 32'h4);

    // Memory never grants.
    phase = 2'd0;
    tick();
    n = 0;
    while (bus.imem_req && n < 40) begin
      n++;
      tick();
    end
`ifdef FETCH_TIMEOUT_EN
    chk32("timeout_cycles", 32'(n), 32'd16);
    chk1("timeout_req", bus.imem_req, 1'b0);
    chk1("timeout_fault", fetch_fault, 1'b1);
    chk1("timeout_stall", stall, 1'b0);
    chk32("timeout_instr", instr, NOP);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0555;
    tick();
    bus_idle();
    chk32("timeout_late_rsp", instr, NOP);
`else
    chk32("no_timeout_cycles", 32'(n), 32'd40);
    chk1("no_timeout_stall", stall, 1'b1);
`endif
    reset_n = 1'b0;
    tick();
    chk1("final_rst_req", bus.imem_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
